// File: rtl/lsb_queue_if.sv
// Memory-side request/ack bus of the load/store queue.
// One outstanding access; request fields are held until ack.
interface lsb_queue_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [1:0]      mem_req_width;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr,
    output mem_req_wdata, mem_req_width,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr,
    input  mem_req_wdata, mem_req_width,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store queue: CDB operand capture, head-only memory issue,
// flush that keeps committed stores and drains in-flight loads.
module lsb_queue #(
  parameter int              DEPTH   = 16,
  parameter int              ROB_W   = 4,
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] IO_BASE = 32'h0003_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [3:0]             disp_op,
  input  logic [ROB_W-1:0]       disp_rob_id,
  input  logic [XLEN-1:0]        disp_vj,
  input  logic [XLEN-1:0]        disp_vk,
  input  logic [ROB_W-1:0]       disp_qj,
  input  logic [ROB_W-1:0]       disp_qk,
  input  logic                   disp_qj_busy,
  input  logic                   disp_qk_busy,
  input  logic [XLEN-1:0]        disp_imm,
  input  logic                   cdb0_valid,
  input  logic [ROB_W-1:0]       cdb0_rob_id,
  input  logic [XLEN-1:0]        cdb0_value,
  input  logic                   cdb1_valid,
  input  logic [ROB_W-1:0]       cdb1_rob_id,
  input  logic [XLEN-1:0]        cdb1_value,
  output logic                   wb_valid,
  output logic [ROB_W-1:0]       wb_rob_id,
  output logic [XLEN-1:0]        wb_value,
  input  logic                   commit_valid,
  input  logic [ROB_W-1:0]       commit_rob_id,
  input  logic [ROB_W-1:0]       rob_head_id,
  lsb_queue_if.master            mem,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic             valid;
    logic             cmt;
    logic [3:0]       op;
    logic [ROB_W-1:0] rob;
    logic             qjb;
    logic [ROB_W-1:0] qj;
    logic [XLEN-1:0]  vj;
    logic             qkb;
    logic [ROB_W-1:0] qk;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  imm;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE, LOAD_WAIT, STORE_WAIT, DRAIN
  } state_t;

  ent_t            q [DEPTH];
  ent_t            hd;
  ent_t            nent;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   off;
  logic [PW-1:0]   cmt_idx;
  logic [PW:0]     cnt;
  logic [PW:0]     ncommit;
  logic [PW:0]     keep_n;
  logic [DEPTH-1:0] keep;
  logic [XLEN:0]   sj [DEPTH];
  logic [XLEN:0]   sk [DEPTH];
  logic [XLEN:0]   dj;
  logic [XLEN:0]   dk;
  logic [XLEN-1:0] addr;
  state_t          state;
  state_t          state_d;
  logic            head_ok;
  logic            fire_ld;
  logic            fire_st;
  logic            push;
  logic            pop;
  logic            pop_ld;
  logic            pop_st;
  logic            cmt_hit;
  logic            wb_q;

  // cdb0 beats cdb1 beats our own writeback on a tag tie
  function automatic logic [XLEN:0] snoop(
    input logic [ROB_W-1:0] tag
  );
    logic [XLEN:0] r;
    r = '0;
    if (wb_valid && wb_rob_id == tag)
      r = {1'b1, wb_value};
    if (cdb1_valid && cdb1_rob_id == tag)
      r = {1'b1, cdb1_value};
    if (cdb0_valid && cdb0_rob_id == tag)
      r = {1'b1, cdb0_value};
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ld_ext(
    input logic [3:0]      op,
    input logic [XLEN-1:0] d
  );
    logic [XLEN-1:0] r;
    unique case (op[1:0])
      2'd0: r = op[2] ? {{(XLEN-8){1'b0}}, d[7:0]}
                      : {{(XLEN-8){d[7]}}, d[7:0]};
      2'd1: r = op[2] ? {{(XLEN-16){1'b0}}, d[15:0]}
                      : {{(XLEN-16){d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign wb_valid   = wb_q && !(rdy && flush);
  assign disp_ready = cnt < FULL;
  assign count      = cnt;

  always_comb begin
    hd      = q[head];
    addr    = hd.vj + hd.imm;
    head_ok = hd.valid && !hd.qjb && !hd.qkb
              && state == IDLE && !flush;
    fire_ld = head_ok && !hd.op[3]
              && (addr < IO_BASE || hd.rob == rob_head_id);
    fire_st = head_ok && hd.op[3] && hd.cmt;
    push    = disp_valid && disp_ready && !flush;
    pop_ld  = state == LOAD_WAIT && mem.mem_ack && !flush;
    pop_st  = state == STORE_WAIT && mem.mem_ack;
    pop     = pop_ld || pop_st;
  end

  always_comb begin
    dj        = snoop(disp_qj);
    dk        = snoop(disp_qk);
    nent      = '0;
    nent.valid = 1'b1;
    nent.op   = disp_op;
    nent.rob  = disp_rob_id;
    nent.imm  = disp_imm;
    nent.qj   = disp_qj;
    nent.qk   = disp_qk;
    nent.qjb  = disp_qj_busy && !dj[XLEN];
    nent.qkb  = disp_qk_busy && !dk[XLEN];
    nent.vj   = (disp_qj_busy && dj[XLEN]) ? dj[XLEN-1:0] : disp_vj;
    nent.vk   = (disp_qk_busy && dk[XLEN]) ? dk[XLEN-1:0] : disp_vk;
  end

  // committed stores are contiguous from head, so a flush keeps a prefix
  always_comb begin
    cmt_hit = 1'b0;
    cmt_idx = '0;
    keep    = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sj[i] = snoop(q[i].qj);
      sk[i] = snoop(q[i].qk);
      if (commit_valid && q[i].valid && q[i].op[3]
          && !q[i].cmt && q[i].rob == commit_rob_id) begin
        cmt_hit = 1'b1;
        cmt_idx = PW'(i);
      end
    end
    keep_n = ncommit + (PW+1)'(cmt_hit);
    for (int i = 0; i < DEPTH; i++) begin
      off     = PW'(i) - head;
      keep[i] = {1'b0, off} < keep_n;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (fire_ld)      state_d = LOAD_WAIT;
        else if (fire_st) state_d = STORE_WAIT;
      end
      LOAD_WAIT: begin
        if (mem.mem_ack) state_d = IDLE;
        else if (flush)  state_d = DRAIN;
      end
      STORE_WAIT: if (mem.mem_ack) state_d = IDLE;
      DRAIN:      if (mem.mem_ack) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      head              <= '0;
      tail              <= '0;
      cnt               <= '0;
      ncommit           <= '0;
      wb_q              <= 1'b0;
      wb_rob_id         <= '0;
      wb_value          <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_we    <= 1'b0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_wdata <= '0;
      mem.mem_req_width <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else if (rdy) begin
      state <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].qjb && sj[i][XLEN]) begin
          q[i].qjb <= 1'b0;
          q[i].vj  <= sj[i][XLEN-1:0];
        end
        if (q[i].qkb && sk[i][XLEN]) begin
          q[i].qkb <= 1'b0;
          q[i].vk  <= sk[i][XLEN-1:0];
        end
        if (cmt_hit && cmt_idx == PW'(i))
          q[i].cmt <= 1'b1;
        if (flush && !keep[i])
          q[i].valid <= 1'b0;
      end
      if (pop)  q[head].valid <= 1'b0;
      if (push) q[tail] <= nent;

      head <= head + PW'(pop);
      if (flush) begin
        tail    <= head + keep_n[PW-1:0];
        cnt     <= keep_n - (PW+1)'(pop);
        ncommit <= keep_n - (PW+1)'(pop_st);
      end else begin
        tail    <= tail + PW'(push);
        cnt     <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        ncommit <= ncommit + (PW+1)'(cmt_hit)
                   - (PW+1)'(pop_st);
      end

      wb_q <= pop_ld;
      if (pop_ld) begin
        wb_rob_id <= hd.rob;
        wb_value  <= ld_ext(hd.op, mem.mem_rdata);
      end

      if (fire_ld || fire_st) begin
        mem.mem_req_valid <= 1'b1;
        mem.mem_req_we    <= hd.op[3];
        mem.mem_req_addr  <= addr;
        mem.mem_req_wdata <= hd.vk;
        mem.mem_req_width <= hd.op[1:0];
      end else if (mem.mem_ack && state != IDLE) begin
        mem.mem_req_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// Scoreboard bench for lsb_queue: expected memory requests and writebacks
// are queued by the stimulus and retired by independent monitors.
module tb_lsb_queue;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
  } wb_t;

  logic        clk = 0;
  logic        rst, rdy, flush;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_op, disp_rob_id, disp_qj, disp_qk;
  logic [31:0] disp_vj, disp_vk, disp_imm;
  logic        disp_qj_busy, disp_qk_busy;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_rob_id, cdb1_rob_id;
  logic [31:0] cdb0_value, cdb1_value;
  logic        wb_valid;
  logic [3:0]  wb_rob_id;
  logic [31:0] wb_value;
  logic        commit_valid;
  logic [3:0]  commit_rob_id, rob_head_id;
  logic [4:0]  count;

  lsb_queue_if #(.XLEN(32)) mem ();

  lsb_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_rob_id(disp_rob_id),
    .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_imm(disp_imm),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id),
    .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id),
    .cdb1_value(cdb1_value),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .rob_head_id(rob_head_id),
    .mem(mem),
    .count(count)
  );

  always #5 clk = ~clk;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 1;
  int   wcnt;
  logic mem_seen;
  req_t cur;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [3:0] rob,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic [31:0] imm,
                          input logic [3:0] qj, input logic qjb,
                          input logic [3:0] qk, input logic qkb);
    disp_valid   = 1;
    disp_op      = op;
    disp_rob_id  = rob;
    disp_vj      = vj;
    disp_vk      = vk;
    disp_imm     = imm;
    disp_qj      = qj;
    disp_qj_busy = qjb;
    disp_qk      = qk;
    disp_qk_busy = qkb;
    step(1);
    disp_valid   = 0;
    disp_qj_busy = 0;
    disp_qk_busy = 0;
  endtask

  task automatic wait_quiet(input int target, input int limit);
    int n = 0;
    while (!(exp_req.size() == 0 && exp_wb.size() == 0 &&
             !mem.mem_req_valid && int'(count) == target) && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_quiet: count=%0d expected %0d, pending req=%0d wb=%0d",
               count, target, exp_req.size(), exp_wb.size());
    end
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    @(negedge clk);
    while (!mem.mem_ack && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem.mem_ack) begin
      errors++;
      $display("FAIL %s: no mem_ack within bound, got 0 expected 1", name);
    end
  endtask

  task automatic push_ld(input logic [3:0] rob, input logic [31:0] a,
                         input logic [1:0] w, input logic [31:0] rd,
                         input logic [31:0] wbv);
    exp_req.push_back('{1'b0, a, 32'h0, w, rd});
    exp_wb.push_back('{rob, wbv});
  endtask

  // memory model: checks each new request against the scoreboard,
  // checks the request stays stable, acks after mem_lat cycles
  initial begin
    mem.mem_ack   = 0;
    mem.mem_rdata = 0;
    mem_seen      = 0;
    wcnt          = 0;
    forever begin
      @(posedge clk);
      #1;
      mem.mem_ack = 0;
      if (!rst && rdy && mem.mem_req_valid) begin
        if (!mem_seen) begin
          mem_seen = 1;
          wcnt     = 0;
          checks++;
          if (exp_req.size() == 0) begin
            errors++;
            cur = '{mem.mem_req_we, mem.mem_req_addr, mem.mem_req_wdata,
                    mem.mem_req_width, 32'h0};
            $display("FAIL mem_req: unexpected request we=%b addr=%h, expected none",
                     mem.mem_req_we, mem.mem_req_addr);
          end else begin
            cur = exp_req.pop_front();
            if (mem.mem_req_we !== cur.we || mem.mem_req_addr !== cur.addr ||
                mem.mem_req_width !== cur.width ||
                (cur.we && mem.mem_req_wdata !== cur.wdata)) begin
              errors++;
              $display("FAIL mem_req: got we=%b addr=%h wdata=%h width=%0d expected we=%b addr=%h wdata=%h width=%0d",
                       mem.mem_req_we, mem.mem_req_addr, mem.mem_req_wdata,
                       mem.mem_req_width, cur.we, cur.addr, cur.wdata,
                       cur.width);
            end
            cur.wdata = mem.mem_req_wdata;
          end
        end else begin
          checks++;
          if (mem.mem_req_addr !== cur.addr || mem.mem_req_we !== cur.we ||
              mem.mem_req_width !== cur.width ||
              mem.mem_req_wdata !== cur.wdata) begin
            errors++;
            $display("FAIL mem_stable: got addr=%h expected addr=%h",
                     mem.mem_req_addr, cur.addr);
          end
          wcnt++;
          if (wcnt >= mem_lat) begin
            mem.mem_ack   = 1;
            mem.mem_rdata = cur.rdata;
            mem_seen      = 0;
          end
        end
      end
    end
  end

  // writeback monitor
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        checks++;
        if (exp_wb.size() == 0) begin
          errors++;
          $display("FAIL wb: unexpected rob=%0d value=%h, expected none",
                   wb_rob_id, wb_value);
        end else begin
          w = exp_wb.pop_front();
          if (wb_rob_id !== w.rob || wb_value !== w.val) begin
            errors++;
            $display("FAIL wb: got rob=%0d value=%h expected rob=%0d value=%h",
                     wb_rob_id, wb_value, w.rob, w.val);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; rdy = 1; flush = 0;
    disp_valid = 0; disp_op = 0; disp_rob_id = 0;
    disp_vj = 0; disp_vk = 0; disp_imm = 0;
    disp_qj = 0; disp_qk = 0; disp_qj_busy = 0; disp_qk_busy = 0;
    cdb0_valid = 0; cdb0_rob_id = 0; cdb0_value = 0;
    cdb1_valid = 0; cdb1_rob_id = 0; cdb1_value = 0;
    commit_valid = 0; commit_rob_id = 0; rob_head_id = 4'hF;
    step(3);
    rst = 0;

    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_req_valid", 32'(mem.mem_req_valid), 0);
    chk("rst_req_we", 32'(mem.mem_req_we), 0);
    chk("rst_req_addr", mem.mem_req_addr, 0);
    chk("rst_req_wdata", mem.mem_req_wdata, 0);
    chk("rst_req_width", 32'(mem.mem_req_width), 0);

    // LW with 3-cycle memory
    mem_lat = 3;
    push_ld(4'd1, 32'h100, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    dispatch(4'b0010, 4'd1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("lw_count", 32'(count), 1);
    wait_quiet(0, 40);

    // byte/half extension
    mem_lat = 1;
    push_ld(4'd2, 32'h104, 2'd0, 32'h1234_5680, 32'hFFFF_FF80);
    push_ld(4'd3, 32'h108, 2'd0, 32'h1234_5680, 32'h0000_0080);
    push_ld(4'd4, 32'h10E, 2'd1, 32'h7777_8001, 32'hFFFF_8001);
    dispatch(4'b0000, 4'd2, 32'h104, 0, 0, 0, 0, 0, 0);
    dispatch(4'b0100, 4'd3, 32'h108, 0, 0, 0, 0, 0, 0);
    dispatch(4'b0001, 4'd4, 32'h10C, 0, 2, 0, 0, 0, 0);
    wait_quiet(0, 60);

    // SW waits for cdb1 data and for commit
    dispatch(4'b1010, 4'd5, 32'h200, 0, 4, 0, 0, 4'd9, 1);
    cdb1_valid = 1; cdb1_rob_id = 4'd9; cdb1_value = 32'h55;
    step(1);
    cdb1_valid = 0;
    step(4);
    chk("sw_held", 32'(mem.mem_req_valid), 0);
    exp_req.push_back('{1'b1, 32'h204, 32'h55, 2'd2, 32'h0});
    commit_valid = 1; commit_rob_id = 4'd5;
    step(1);
    commit_valid = 0;
    wait_quiet(0, 30);

    // dispatch bypass, cdb0 wins tie
    push_ld(4'd8, 32'h308, 2'd2, 32'hCAFE_0001, 32'hCAFE_0001);
    cdb0_valid = 1; cdb0_rob_id = 4'd7; cdb0_value = 32'h300;
    cdb1_valid = 1; cdb1_rob_id = 4'd7; cdb1_value = 32'h999;
    dispatch(4'b0010, 4'd8, 0, 0, 8, 4'd7, 1, 0, 0);
    cdb0_valid = 0; cdb1_valid = 0;
    wait_quiet(0, 30);

    // flush keeps two committed stores, drops three loads
    mem_lat = 4;
    exp_req.push_back('{1'b1, 32'h400, 32'h11, 2'd2, 32'h0});
    exp_req.push_back('{1'b1, 32'h404, 32'h22, 2'd2, 32'h0});
    dispatch(4'b1010, 4'd10, 32'h400, 32'h11, 0, 0, 0, 0, 0);
    dispatch(4'b1010, 4'd11, 32'h400, 32'h22, 4, 0, 0, 0, 0);
    dispatch(4'b0010, 4'd12, 32'h600, 0, 0, 0, 0, 0, 0);
    dispatch(4'b0010, 4'd13, 32'h600, 0, 4, 0, 0, 0, 0);
    dispatch(4'b0010, 4'd14, 32'h600, 0, 8, 0, 0, 0, 0);
    chk("pre_flush_count", 32'(count), 5);
    commit_valid = 1; commit_rob_id = 4'd10;
    step(1);
    commit_rob_id = 4'd11;
    step(1);
    commit_valid = 0;
    flush = 1;
    step(1);
    flush = 0;
    chk("flush_keep_count", 32'(count), 2);
    wait_quiet(0, 60);

    // flush during an in-flight load: data dropped, no writeback
    exp_req.push_back('{1'b0, 32'h500, 32'h0, 2'd2, 32'h0000_0BAD});
    dispatch(4'b0010, 4'd6, 32'h500, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 10 && !mem.mem_req_valid; n++) step(1);
    chk("drain_req", 32'(mem.mem_req_valid), 1);
    flush = 1;
    step(1);
    flush = 0;
    chk("drain_count", 32'(count), 0);
    step(8);
    chk("drain_done", 32'(mem.mem_req_valid), 0);
    mem_lat = 1;
    push_ld(4'd7, 32'h508, 2'd2, 32'h1234_5678, 32'h1234_5678);
    dispatch(4'b0010, 4'd7, 32'h500, 0, 8, 0, 0, 0, 0);
    wait_quiet(0, 30);

    // fill with IO loads held behind rob_head_id, then wrap
    rob_head_id = 4'd5;
    mem_lat = 2;
    for (int i = 0; i < 16; i++)
      dispatch(4'b0010, 4'(i), 32'h30000, 0, 32'(i * 4), 0, 0, 0, 0);
    chk("full_count", 32'(count), 16);
    chk("full_ready", 32'(disp_ready), 0);
    step(3);
    chk("io_held", 32'(mem.mem_req_valid), 0);
    push_ld(4'd0, 32'h30000, 2'd2, 32'h1000, 32'h1000);
    rob_head_id = 4'd0;
    step(1);
    chk("io_issue", 32'(mem.mem_req_valid), 1);
    wait_ack("io_ack0");
    @(posedge clk); #1;
    chk("pop_count", 32'(count), 15);
    dispatch(4'b0010, 4'd0, 32'h30000, 0, 32'h40, 0, 0, 0, 0);
    chk("refill_count", 32'(count), 16);
    chk("refill_ready", 32'(disp_ready), 0);
    push_ld(4'd1, 32'h30004, 2'd2, 32'h1001, 32'h1001);
    rob_head_id = 4'd1;
    wait_ack("io_ack1");
    @(posedge clk); #1;
    chk("pop2_count", 32'(count), 15);
    push_ld(4'd2, 32'h30008, 2'd2, 32'h1002, 32'h1002);
    rob_head_id = 4'd2;
    wait_ack("io_ack2");
    disp_valid = 1; disp_op = 4'b0010; disp_rob_id = 4'd1;
    disp_vj = 32'h30000; disp_imm = 32'h44;
    @(posedge clk); #1;
    disp_valid = 0;
    chk("pop_push_count", 32'(count), 15);
    wait_quiet(15, 10);
    flush = 1;
    step(1);
    flush = 0;
    rob_head_id = 4'hF;
    chk("final_flush_count", 32'(count), 0);
    step(3);
    chk("final_idle", 32'(mem.mem_req_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
